encoder8_3_seq: RTL and testbench

Sequential 8-to-3 request encoder; the inverse of the 3-to-8 line decoder. It captures pulses on eight request lines D7..D0 into a pending register. Pending requests are emitted one at a time as a 3-bit index A on a valid/ready output. Each accepted index clears its pending bit. Used wherever one-hot events from decoded logic must be serialised back into binary codes.

---
 rtl/encoder8_3_seq_if.sv | 14 +
 rtl/encoder8_3_seq.sv | 150 +++++++++++++++
 tb/tb_encoder8_3_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/encoder8_3_seq_if.sv
// Request/grant bundle for encoder8_3_seq: one-hot request lines in,
// encoded index out on a valid/ready handshake, plus debug status.
interface encoder8_3_seq_if;
  logic [7:0] D;
  logic       ready;
  logic [2:0] A;
  logic       valid;
  logic [7:0] pending;
  logic       overrun;

  // master: request source / index consumer; slave: the encoder itself
  modport master (output D, output ready, input A, input valid, input pending, input overrun);
  modport slave  (input D, input ready, output A, output valid, output pending, output overrun);
endinterface

// File: rtl/encoder8_3_seq.sv
// Sequential 8-to-3 request encoder: latches request pulses and serialises them
// as 3-bit indices. Define ENCODER_ROUND_ROBIN_EN for rotating priority.
module encoder8_3_seq (
  input  logic               clk,
  input  logic               rst,
  encoder8_3_seq_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] a_r;
  logic [2:0] a_nxt_s;
  logic       valid_r;
  logic [7:0] pending_r;
  logic [7:0] pending_nxt_s;
  logic       overrun_r;
  logic       overrun_nxt_s;
  logic       accept_s;
  logic [7:0] clr_s;
  logic [7:0] keep_s;
  logic [7:0] search_vec_s;
  logic [2:0] sel_idx_s;

  function automatic logic [7:0] onehot3(input logic [2:0] idx);
    onehot3 = 8'b0000_0001 << idx;
  endfunction

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [2:0] ptr_r;
  logic [2:0] ptr_nxt_s;

  // Descend from base with wrap-around; the first set bit found wins.
  function automatic logic [2:0] select_idx(input logic [7:0] vec, input logic [2:0] base);
    logic       found;
    logic [2:0] idx;
    logic [2:0] result;
    found  = 1'b0;
    result = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx    = base - 3'(k);
      result = (!found && vec[idx]) ? idx : result;
      found  = found | vec[idx];
    end
    return result;
  endfunction
`else
  // Fixed priority: scanning upward lets the highest set bit overwrite.
  function automatic logic [2:0] select_idx(input logic [7:0] vec);
    logic [2:0] result;
    result = 3'd0;
    for (int i = 0; i < 8; i++) begin
      result = vec[i] ? 3'(i) : result;
    end
    return result;
  endfunction
`endif

  // Pending/overrun next values and the vector the next grant is chosen from.
  always_comb begin
    accept_s      = valid_r & bus.ready;
    clr_s         = accept_s ? onehot3(a_r) : 8'h00;
    keep_s        = pending_r & ~clr_s;
    pending_nxt_s = keep_s | bus.D;
    overrun_nxt_s = overrun_r | (|(bus.D & keep_s));
    // D is deliberately excluded: new requests never join this cycle's selection
    search_vec_s  = valid_r ? keep_s : pending_r;
`ifdef ENCODER_ROUND_ROBIN_EN
    ptr_nxt_s     = accept_s ? (a_r - 3'd1) : ptr_r;
    sel_idx_s     = select_idx(search_vec_s, ptr_nxt_s);
`else
    sel_idx_s     = select_idx(search_vec_s);
`endif
  end

  // Next-state and next-index logic for the IDLE/PRESENT handshake.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    case (state_r)
      ST_IDLE: begin
        if (pending_r != 8'h00) begin
          state_nxt_s = ST_PRESENT;
          a_nxt_s     = sel_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (accept_s) begin
          if (keep_s != 8'h00) begin
            a_nxt_s = sel_idx_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_PRESENT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Handshake state and presented index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_r     <= 3'd0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      valid_r <= (state_nxt_s == ST_PRESENT);
    end
  end

  // Pending requests and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 8'h00;
      overrun_r <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      overrun_r <= overrun_nxt_s;
    end
  end

`ifdef ENCODER_ROUND_ROBIN_EN
  // Rotating priority pointer: restarts the search just below the last grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 3'd7;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end
`endif

  assign bus.A       = a_r;
  assign bus.valid   = valid_r;
  assign bus.pending = pending_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_encoder8_3_seq.sv
// Bench for encoder8_3_seq: directed test-plan scenarios with literal
// expectations plus randomized traffic against a request-queue style model.
module tb_encoder8_3_seq;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  encoder8_3_seq_if bus ();

  encoder8_3_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  bit [7:0] m_pend;
  int       m_a;
  bit       m_valid;
  bit       m_ovr;
  int       m_ptr;
  bit       model_live;

  function automatic int pick(input bit [7:0] v, input int start);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (start - k + 8) % 8;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  initial model_live = 1'b0;

  always @(posedge clk) begin
    bit [7:0] dreq;
    bit [7:0] survivors;
    bit       acc;
    dreq = bus.D;
    if (rst) begin
      m_pend = 8'h00; m_a = 0; m_valid = 1'b0; m_ovr = 1'b0; m_ptr = 7;
    end else begin
      acc = m_valid && bus.ready;
      survivors = m_pend;
      if (acc) survivors[m_a] = 1'b0;
      for (int i = 0; i < 8; i++)
        if (dreq[i] && survivors[i]) m_ovr = 1'b1;
      if (!m_valid) begin
        if (m_pend != 8'h00) begin
`ifdef ENCODER_ROUND_ROBIN_EN
          m_a = pick(m_pend, m_ptr);
`else
          m_a = pick(m_pend, 7);
`endif
          m_valid = 1'b1;
        end
      end else if (acc) begin
`ifdef ENCODER_ROUND_ROBIN_EN
        m_ptr = (m_a + 7) % 8;
        if (survivors != 8'h00) m_a = pick(survivors, m_ptr);
`else
        if (survivors != 8'h00) m_a = pick(survivors, 7);
`endif
        else m_valid = 1'b0;
      end
      m_pend = survivors | dreq;
    end
    model_live = 1'b1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_live) begin
      vectors++;
      if (bus.A !== 3'(m_a) || bus.valid !== m_valid ||
          bus.pending !== m_pend || bus.overrun !== m_ovr) begin
        miscompares++;
        $display("FAIL model t=%0t: got A=%0d valid=%b pending=%h overrun=%b, want A=%0d valid=%b pending=%h overrun=%b",
                 $time, bus.A, bus.valid, bus.pending, bus.overrun, m_a, m_valid, m_pend, m_ovr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [7:0] d, input logic r, input logic rs);
    @(posedge clk);
    #2;
    bus.D     = d;
    bus.ready = r;
    rst       = rs;
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    step(8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.D       = 8'hFF;
    bus.ready   = 1'b0;
    rst         = 1'b1;

    // Reset with all requests asserted
    for (int c = 0; c < 2; c++) begin
      step(8'hFF, 1'b0, 1'b1);
      chk("rst_A", 8'(bus.A), 8'd0);
      chk("rst_valid", 8'(bus.valid), 8'd0);
      chk("rst_pending", bus.pending, 8'h00);
      chk("rst_overrun", 8'(bus.overrun), 8'd0);
    end
    step(8'h00, 1'b0, 1'b0);
    chk("rst_release_pending", bus.pending, 8'h00);
    step(8'h00, 1'b0, 1'b0);
    chk("rst_after_pending", bus.pending, 8'h00);

    // Fixed ordering
    do_reset();
    step(8'hA4, 1'b1, 1'b0);                        // cycle 0
    step(8'h00, 1'b1, 1'b0);                        // cycle 1
    chk("ord_pend_c1", bus.pending, 8'hA4);
    step(8'h00, 1'b1, 1'b0);  chk("ord_A_c2", 8'(bus.A), 8'd7);
    chk("ord_valid_c2", 8'(bus.valid), 8'd1);
    step(8'h00, 1'b1, 1'b0);  chk("ord_A_c3", 8'(bus.A), 8'd5);
    step(8'h00, 1'b1, 1'b0);  chk("ord_A_c4", 8'(bus.A), 8'd2);
    step(8'h00, 1'b1, 1'b0);  chk("ord_valid_c5", 8'(bus.valid), 8'd0);
    chk("ord_pend_c5", bus.pending, 8'h00);

    // Backpressure
    do_reset();
    step(8'h08, 1'b0, 1'b0);                        // cycle 0
    step(8'h00, 1'b0, 1'b0);                        // cycle 1
    for (int c = 2; c <= 6; c++) begin
      step(8'h00, (c == 6) ? 1'b1 : 1'b0, 1'b0);
      chk("bp_valid", 8'(bus.valid), 8'd1);
      chk("bp_A", 8'(bus.A), 8'd3);
    end
    step(8'h00, 1'b0, 1'b0);  chk("bp_valid_c7", 8'(bus.valid), 8'd0);

    // Overrun: same request raised twice while still pending
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      step((c == 0 || c == 3) ? 8'h10 : 8'h00, (c >= 5) ? 1'b1 : 1'b0, 1'b0);
      if (c == 3) chk("ovr_c3", 8'(bus.overrun), 8'd0);
      if (c >= 4) chk("ovr_sticky", 8'(bus.overrun), 8'd1);
    end
    chk("ovr_drained", bus.pending, 8'h00);

    // Re-pend of the index being accepted
    do_reset();
    step(8'h01, 1'b0, 1'b0);                        // cycle 0
    step(8'h00, 1'b0, 1'b0);                        // cycle 1
    step(8'h00, 1'b0, 1'b0);  chk("rp_A_c2", 8'(bus.A), 8'd0);
    step(8'h01, 1'b1, 1'b0);                        // cycle 3: accept + re-raise
    step(8'h00, 1'b0, 1'b0);  chk("rp_pend_c4", bus.pending, 8'h01);
    chk("rp_ovr_c4", 8'(bus.overrun), 8'd0);
    step(8'h00, 1'b0, 1'b0);  chk("rp_valid_c5", 8'(bus.valid), 8'd1);
    chk("rp_A_c5", 8'(bus.A), 8'd0);
    chk("rp_ovr_c5", 8'(bus.overrun), 8'd0);

    // Priority mode
    do_reset();
    step(8'h85, 1'b0, 1'b0);                        // cycle 0
    step(8'h00, 1'b0, 1'b0);                        // cycle 1
    step(8'h00, 1'b0, 1'b0);  chk("pr_A_c2", 8'(bus.A), 8'd7);
    step(8'h00, 1'b0, 1'b0);  chk("pr_A_c3", 8'(bus.A), 8'd7);
    step(8'h80, 1'b1, 1'b0);  chk("pr_A_c4", 8'(bus.A), 8'd7);
    step(8'h00, 1'b1, 1'b0);  chk("pr_A_c5", 8'(bus.A), 8'd2);
    step(8'h00, 1'b0, 1'b0);
`ifdef ENCODER_ROUND_ROBIN_EN
    chk("pr_A_c6", 8'(bus.A), 8'd0);
`else
    chk("pr_A_c6", 8'(bus.A), 8'd7);
`endif
    chk("pr_ovr_c6", 8'(bus.overrun), 8'd0);

    // Randomized traffic, checked by the model every cycle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step(8'($urandom & $urandom & $urandom),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0);
    end
    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
